// File: rtl/core.sv
// Output-stationary 8x8 MAC core: xmem -> L0/L1 -> skewed PE array
// -> OFIFO -> pmem -> SFP, all steered by one 64-bit word per cycle.
module core #(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int col     = 8,
  parameter int row     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [63:0]            inst,
  input  logic [bw*row-1:0]      D_xmem,
  output logic                   ofifo_valid,
  output logic [col*psum_bw-1:0] sfp_out
);

  localparam int XW = bw * row;
  localparam int PW = col * psum_bw;
  localparam int SD = (row > col) ? row : col;
  localparam int RI = $clog2(row);

  logic        pass_psum, recall_psum, l1_wr, os_en, sfu_pt;
  logic        cen_p, wen_p, cen_x, wen_x;
  logic        ofifo_rd, l0_rd, l0_wr, execute;
  logic [10:0] a_p, a_x;
  logic        unused_bits;

  assign pass_psum   = inst[39];
  assign recall_psum = inst[38];
  assign l1_wr       = inst[37];
  assign os_en       = inst[36];
  assign sfu_pt      = inst[34];
  assign cen_p       = inst[32];
  assign wen_p       = inst[31];
  assign a_p         = inst[30:20];
  assign cen_x       = inst[19];
  assign wen_x       = inst[18];
  assign a_x         = inst[17:7];
  assign ofifo_rd    = inst[6];
  assign l0_rd       = inst[3];
  assign l0_wr       = inst[2];
  assign execute     = inst[1];
  assign unused_bits = ^{inst[63:40], inst[35], inst[33],
                         inst[5:4], inst[0]};

  // xmem: single-port, active-low strobes, Q holds when idle
  logic [XW-1:0] xmem_q [0:2047];
  logic [XW-1:0] xq_q;

  always_ff @(posedge clk) begin
    if (!cen_x) begin
      if (!wen_x) xmem_q[a_x] <= D_xmem;
      else        xq_q <= xmem_q[a_x];
    end
  end

  logic [XW-1:0] l0_q [0:8];
  logic [XW-1:0] l1_q [0:8];
  logic [3:0]    ptr_q;
  logic [XW-1:0] act_q, wgt_q;

  always_ff @(posedge clk) begin
    if (l0_wr) begin
      for (int i = 0; i < 8; i++) l0_q[i] <= l0_q[i+1];
      l0_q[8] <= xq_q;
    end
    if (l1_wr) begin
      for (int i = 0; i < 8; i++) l1_q[i] <= l1_q[i+1];
      l1_q[8] <= xq_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
      act_q <= '0;
      wgt_q <= '0;
    end else if (l0_wr || l1_wr) begin
      ptr_q <= '0;
    end else if (l0_rd) begin
      if (ptr_q < 4'd9) begin
        act_q <= l0_q[ptr_q];
        wgt_q <= l1_q[ptr_q];
        ptr_q <= ptr_q + 4'd1;
      end else begin
        act_q <= '0;
        wgt_q <= '0;
      end
    end
  end

  // Stage k of the skew pipe feeds row/column k, giving delay k
  logic          tok_v;
  logic [XW-1:0] sa_q [0:SD-1];
  logic [XW-1:0] sw_q [0:SD-1];
  logic [SD-1:0] sv_q;

  assign tok_v = execute & os_en;

  always_ff @(posedge clk) begin
    if (reset) sv_q <= '0;
    else       sv_q <= {sv_q[SD-2:0], tok_v};
  end

  always_ff @(posedge clk) begin
    sa_q[0] <= act_q;
    sw_q[0] <= wgt_q;
    for (int k = 1; k < SD; k++) begin
      sa_q[k] <= sa_q[k-1];
      sw_q[k] <= sw_q[k-1];
    end
  end

  logic [bw-1:0]      pa_q  [0:row-1][0:col-1];
  logic [bw-1:0]      pw_q  [0:row-1][0:col-1];
  logic               pav_q [0:row-1][0:col-1];
  logic               pwv_q [0:row-1][0:col-1];
  logic [psum_bw-1:0] acc_q [0:row-1][0:col-1];
  logic [bw-1:0]      ai    [0:row-1][0:col-1];
  logic [bw-1:0]      wi    [0:row-1][0:col-1];
  logic               vai   [0:row-1][0:col-1];
  logic               vwi   [0:row-1][0:col-1];

  always_comb begin
    for (int r = 0; r < row; r++) begin
      ai[r][0]  = sa_q[r][bw*r +: bw];
      vai[r][0] = sv_q[r];
      for (int c = 1; c < col; c++) begin
        ai[r][c]  = pa_q[r][c-1];
        vai[r][c] = pav_q[r][c-1];
      end
    end
    for (int c = 0; c < col; c++) begin
      wi[0][c]  = sw_q[c][bw*c +: bw];
      vwi[0][c] = sv_q[c];
      for (int r = 1; r < row; r++) begin
        wi[r][c]  = pw_q[r-1][c];
        vwi[r][c] = pwv_q[r-1][c];
      end
    end
  end

  // Unsigned act times signed weight, wrapping at psum_bw
  function automatic logic [psum_bw-1:0] mac(
    input logic [psum_bw-1:0] acc,
    input logic [bw-1:0]      a,
    input logic [bw-1:0]      w
  );
    logic [psum_bw-1:0] ax, wx;
    ax = {{(psum_bw-bw){1'b0}}, a};
    wx = {{(psum_bw-bw){w[bw-1]}}, w};
    return acc + ax * wx;
  endfunction

  always_ff @(posedge clk) begin
    for (int r = 0; r < row; r++) begin
      for (int c = 0; c < col; c++) begin
        if (reset) begin
          pa_q[r][c]  <= '0;
          pw_q[r][c]  <= '0;
          pav_q[r][c] <= 1'b0;
          pwv_q[r][c] <= 1'b0;
          acc_q[r][c] <= '0;
        end else begin
          pa_q[r][c]  <= ai[r][c];
          pw_q[r][c]  <= wi[r][c];
          pav_q[r][c] <= vai[r][c];
          pwv_q[r][c] <= vwi[r][c];
          if (vai[r][c] && vwi[r][c])
            acc_q[r][c] <= mac(acc_q[r][c], ai[r][c], wi[r][c]);
        end
      end
    end
  end

  logic [PW-1:0] rw [0:row-1];

  always_comb begin
    for (int r = 0; r < row; r++) begin
      rw[r] = '0;
      for (int c = 0; c < col; c++)
        rw[r][psum_bw*c +: psum_bw] = acc_q[r][c];
    end
  end

  logic [PW-1:0] fifo_q [0:row-1];
  logic [RI:0]   cnt_q;
  logic [RI-1:0] pidx;
  logic [PW-1:0] out_q;
  logic          out_vld_q;

  assign pidx        = RI'(cnt_q - 1'b1);
  assign ofifo_valid = (cnt_q != '0);

  always_ff @(posedge clk) begin
    if (recall_psum)
      for (int r = 0; r < row; r++) fifo_q[r] <= rw[r];
  end

  // Pops run from the highest row down
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
    end else begin
      if (recall_psum)
        cnt_q <= (RI+1)'(row);
      else if (ofifo_rd && ofifo_valid)
        cnt_q <= cnt_q - 1'b1;
      if (ofifo_rd) begin
        out_vld_q <= ofifo_valid;
        if (ofifo_valid) out_q <= fifo_q[pidx];
      end
    end
  end

  logic [PW-1:0] pmem_q [0:2047];
  logic [10:0]   ap_d_q;
  logic          p_wr, p_rd;
  logic [PW-1:0] p_rdata, sfp_d;

  assign p_wr    = !cen_p && ((pass_psum && out_vld_q) || !wen_p);
  assign p_rd    = !cen_p && !p_wr;
  assign p_rdata = pmem_q[a_p];

  always_comb begin
    sfp_d = p_rdata;
    for (int c = 0; c < col; c++)
      if (!sfu_pt && p_rdata[psum_bw*c + psum_bw-1])
        sfp_d[psum_bw*c +: psum_bw] = '0;
  end

  always_ff @(posedge clk) begin
    if (p_wr) pmem_q[ap_d_q] <= out_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ap_d_q  <= '0;
      sfp_out <= '0;
    end else begin
      ap_d_q <= a_p;
      if (p_rd) sfp_out <= sfp_d;
    end
  end

endmodule

// File: tb/tb_core.sv
// Randomized bench for core: xmem/L0 staging, MAC bursts against a
// lane-wise arithmetic model, drain ordering, SFP and reset behaviour.
module tb_core;

  logic         clk = 1'b0;
  logic         reset;
  logic [63:0]  inst;
  logic [31:0]  D_xmem;
  logic         ofifo_valid;
  logic [127:0] sfp_out;

  int checks   = 0;
  int failures = 0;

  core dut (
    .clk        (clk),
    .reset      (reset),
    .inst       (inst),
    .D_xmem     (D_xmem),
    .ofifo_valid(ofifo_valid),
    .sfp_out    (sfp_out)
  );

  always #5 clk = ~clk;

  localparam logic [63:0] IDLE = (64'd1 << 36) | (64'd1 << 32) |
                                 (64'd1 << 31) | (64'd1 << 19) |
                                 (64'd1 << 18);

  logic [31:0] xm [0:2047];
  int          em [8][8];

  task automatic tick(input logic [63:0] i, input logic [31:0] d);
    inst   = i;
    D_xmem = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(IDLE, 32'd0);
    reset = 1'b0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) em[r][c] = 0;
  endtask

  task automatic xwrite(input int a, input logic [31:0] d);
    logic [63:0] i;
    i = IDLE; i[19] = 1'b0; i[18] = 1'b0; i[17:7] = 11'(a);
    tick(i, d);
    xm[a] = d;
  endtask

  task automatic xread(input int a);
    logic [63:0] i;
    i = IDLE; i[19] = 1'b0; i[17:7] = 11'(a);
    tick(i, 32'd0);
  endtask

  task automatic load_buf(input int base, input bit l1);
    logic [63:0] i;
    for (int j = 0; j < 10; j++) begin
      i = IDLE;
      if (j < 9) begin i[19] = 1'b0; i[17:7] = 11'(base + j); end
      if (j >= 1) i[l1 ? 37 : 2] = 1'b1;
      tick(i, 32'd0);
    end
  endtask

  task automatic run_burst(input int ic, input bit os);
    logic [63:0] i;
    int a, w;
    load_buf(ic * 9, 1'b0);
    load_buf(576 + ic * 9, 1'b1);
    for (int j = 0; j < 10; j++) begin
      i = IDLE;
      if (!os) i[36] = 1'b0;
      if (j < 9) i[3] = 1'b1;
      if (j >= 1) i[1] = 1'b1;
      tick(i, 32'd0);
    end
    if (os)
      for (int k = 0; k < 9; k++)
        for (int r = 0; r < 8; r++)
          for (int c = 0; c < 8; c++) begin
            a = int'(xm[ic*9 + k][4*r +: 4]);
            w = int'(xm[576 + ic*9 + k][4*c +: 4]);
            if (w >= 8) w = w - 16;
            em[r][c] = em[r][c] + a * w;
          end
  endtask

  task automatic settle();
    repeat (17) tick(IDLE, 32'd0);
  endtask

  task automatic drain(input int base, output logic v1, output logic v2);
    logic [63:0] i;
    i = IDLE; i[38] = 1'b1;
    tick(i, 32'd0);
    v1 = ofifo_valid;
    i = IDLE; i[6] = 1'b1; i[39] = 1'b1; i[30:20] = 11'(base + 7);
    tick(i, 32'd0);
    for (int j = 0; j < 8; j++) begin
      i = IDLE; i[6] = 1'b1; i[39] = 1'b1; i[32] = 1'b0;
      i[30:20] = 11'(base + 6 - j);
      tick(i, 32'd0);
    end
    v2 = ofifo_valid;
  endtask

  task automatic pread(input int a, input bit pt);
    logic [63:0] i;
    i = IDLE; i[32] = 1'b0; i[30:20] = 11'(a); i[34] = pt;
    tick(i, 32'd0);
  endtask

  function automatic logic [127:0] exp_row(input int r, input bit pt);
    logic [127:0] res;
    logic [15:0]  v;
    res = '0;
    for (int c = 0; c < 8; c++) begin
      v = 16'(em[r][c]);
      if (!pt && v[15]) v = 16'd0;
      res[16*c +: 16] = v;
    end
    return res;
  endfunction

  task automatic test_reset();
    do_reset();
    checks++;
    if (ofifo_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_ofifo_valid got=%b exp=0", ofifo_valid);
    end
    checks++;
    if (sfp_out !== 128'd0) begin
      failures++;
      $display("FAIL reset_sfp_out got=%h exp=0", sfp_out);
    end
  endtask

  task automatic test_xmem();
    for (int a = 0; a < 72; a++) xwrite(a, $urandom);
    for (int a = 576; a < 648; a++) xwrite(a, $urandom);
    xread(5);
    checks++;
    if (dut.xq_q !== xm[5]) begin
      failures++;
      $display("FAIL xmem_rd5 got=%h exp=%h", dut.xq_q, xm[5]);
    end
    do_reset();
    xread(5);
    checks++;
    if (dut.xq_q !== xm[5]) begin
      failures++;
      $display("FAIL xmem_rd5_after_reset got=%h exp=%h", dut.xq_q, xm[5]);
    end
    xread(600);
    checks++;
    if (dut.xq_q !== xm[600]) begin
      failures++;
      $display("FAIL xmem_rd600 got=%h exp=%h", dut.xq_q, xm[600]);
    end
  endtask

  task automatic test_l0();
    logic [63:0] i;
    logic [31:0] e;
    for (int j = 0; j < 11; j++) begin
      i = IDLE;
      if (j < 10) begin
        i[19] = 1'b0;
        i[17:7] = (j == 0) ? 11'd0 : 11'(j - 1);
      end
      if (j >= 1) i[2] = 1'b1;
      tick(i, 32'd0);
    end
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (dut.l0_q[k] !== xm[k]) begin
        failures++;
        $display("FAIL l0_entry%0d got=%h exp=%h", k, dut.l0_q[k], xm[k]);
      end
    end
    for (int k = 0; k < 10; k++) begin
      i = IDLE; i[3] = 1'b1;
      tick(i, 32'd0);
      e = (k < 9) ? xm[k] : 32'd0;
      checks++;
      if (dut.act_q !== e) begin
        failures++;
        $display("FAIL l0_rd%0d got=%h exp=%h", k, dut.act_q, e);
      end
    end
  endtask

  task automatic test_ones();
    logic v1, v2;
    for (int a = 0; a < 72; a++) xwrite(a, 32'h1111_1111);
    for (int a = 576; a < 648; a++) xwrite(a, 32'h1111_1111);
    do_reset();
    for (int ic = 0; ic < 8; ic++) run_burst(ic, 1'b1);
    settle();
    drain(0, v1, v2);
    checks++;
    if (v1 !== 1'b1) begin
      failures++;
      $display("FAIL ones_valid_after_recall got=%b exp=1", v1);
    end
    checks++;
    if (v2 !== 1'b0) begin
      failures++;
      $display("FAIL ones_valid_after_pops got=%b exp=0", v2);
    end
    for (int r = 0; r < 8; r++) begin
      pread(r, 1'b1);
      checks++;
      if (sfp_out !== exp_row(r, 1'b1)) begin
        failures++;
        $display("FAIL ones_pmem%0d got=%h exp=%h", r, sfp_out, exp_row(r, 1'b1));
      end
    end
  endtask

  task automatic test_neg_relu();
    xwrite(0, 32'hFFFF_FFFF);
    xwrite(576, 32'hFFFF_FFFF);
    for (int k = 1; k < 9; k++) begin
      xwrite(k, 32'd0);
      xwrite(576 + k, 32'd0);
    end
    do_reset();
    run_burst(0, 1'b1);
    settle();
    begin
      logic v1, v2;
      drain(0, v1, v2);
    end
    pread(7, 1'b1);
    checks++;
    if (sfp_out !== exp_row(7, 1'b1)) begin
      failures++;
      $display("FAIL neg_pass got=%h exp=%h", sfp_out, exp_row(7, 1'b1));
    end
    pread(7, 1'b0);
    checks++;
    if (sfp_out !== exp_row(7, 1'b0)) begin
      failures++;
      $display("FAIL neg_relu got=%h exp=%h", sfp_out, exp_row(7, 1'b0));
    end
    tick(IDLE, 32'd0);
    checks++;
    if (sfp_out !== exp_row(7, 1'b0)) begin
      failures++;
      $display("FAIL sfp_hold got=%h exp=%h", sfp_out, exp_row(7, 1'b0));
    end
    pread(0, 1'b1);
    pread(7, 1'b1);
    checks++;
    if (sfp_out !== exp_row(7, 1'b1)) begin
      failures++;
      $display("FAIL neg_reread got=%h exp=%h", sfp_out, exp_row(7, 1'b1));
    end
  endtask

  task automatic test_random();
    logic v1, v2;
    for (int a = 0; a < 72; a++) xwrite(a, $urandom);
    for (int a = 576; a < 648; a++) xwrite(a, $urandom);
    do_reset();
    run_burst(0, 1'b1);
    run_burst(1, 1'b0);
    run_burst(2, 1'b1);
    run_burst(5, 1'b1);
    settle();
    drain(16, v1, v2);
    checks++;
    if (v1 !== 1'b1 || v2 !== 1'b0) begin
      failures++;
      $display("FAIL rand_valid got=%b%b exp=10", v1, v2);
    end
    for (int r = 0; r < 8; r++) begin
      pread(16 + r, 1'b1);
      checks++;
      if (sfp_out !== exp_row(r, 1'b1)) begin
        failures++;
        $display("FAIL rand_pass_row%0d got=%h exp=%h", r, sfp_out, exp_row(r, 1'b1));
      end
      pread(16 + r, 1'b0);
      checks++;
      if (sfp_out !== exp_row(r, 1'b0)) begin
        failures++;
        $display("FAIL rand_relu_row%0d got=%h exp=%h", r, sfp_out, exp_row(r, 1'b0));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic v1, v2;
    run_burst(3, 1'b1);
    settle();
    drain(32, v1, v2);
    for (int r = 0; r < 8; r++) begin
      pread(32 + r, 1'b1);
      checks++;
      if (sfp_out !== exp_row(r, 1'b1)) begin
        failures++;
        $display("FAIL accum_row%0d got=%h exp=%h", r, sfp_out, exp_row(r, 1'b1));
      end
    end
  endtask

  task automatic test_reset_exec();
    logic [63:0] i;
    logic v1, v2;
    i = IDLE; i[38] = 1'b1;
    tick(i, 32'd0);
    load_buf(0, 1'b0);
    load_buf(576, 1'b1);
    for (int j = 0; j < 6; j++) begin
      i = IDLE; i[3] = 1'b1;
      if (j >= 1) i[1] = 1'b1;
      tick(i, 32'd0);
    end
    i = IDLE; i[3] = 1'b1; i[1] = 1'b1;
    reset = 1'b1;
    tick(i, 32'd0);
    reset = 1'b0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) em[r][c] = 0;
    checks++;
    if (ofifo_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_exec_valid got=%b exp=0", ofifo_valid);
    end
    checks++;
    if (sfp_out !== 128'd0) begin
      failures++;
      $display("FAIL rst_exec_sfp got=%h exp=0", sfp_out);
    end
    settle();
    drain(40, v1, v2);
    for (int r = 0; r < 8; r++) begin
      pread(40 + r, 1'b1);
      checks++;
      if (sfp_out !== exp_row(r, 1'b1)) begin
        failures++;
        $display("FAIL rst_exec_row%0d got=%h exp=%h", r, sfp_out, exp_row(r, 1'b1));
      end
    end
  endtask

  initial begin
    reset  = 1'b1;
    inst   = IDLE;
    D_xmem = 32'd0;
    test_reset();
    test_xmem();
    test_l0();
    test_ones();
    test_neg_relu();
    test_random();
    test_back_to_back();
    test_reset_exec();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
